seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_decode.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the seven-segment display blocks.
//   Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
//   Also holds the scan FSM state encoding and the input shadow record.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Inputs frozen once per frame so a frame never mixes old and new digits.
  typedef struct packed {
    logic       sign;
    logic       lz;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
  } shadow_t;

endpackage

// File: rtl/seg_decode.sv
// seg_decode -- combinational BCD to seven-segment decoder.
//   bcd_i   : 4-bit BCD digit; codes 10-15 show an 'E'
//   blank_i : 1 forces all segments off
//   seg_o   : {g,f,e,d,c,b,a}, active-low
import seg_pkg::*;

module seg_decode (
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the digit value.
  always_comb begin
    seg_o = SEG_E;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- multiplexed 4-digit seven-segment scan controller.
//   Each digit slot lasts CLK_DIV cycles: BLANK_CYC dark cycles (anti-ghosting)
//   followed by the digit drive. Digit 3 shows a minus sign or blank, digits
//   2..0 show BCD with optional leading-zero suppression.
//   clk, rst        : clock, synchronous active-high reset
//   en              : scan enable (0 = display dark, scan restarts at digit 0)
//   sign, bcd2..0,
//   lz_suppress     : display value, captured once per frame
//   anode           : digit select, active-low, bit n = digit n
//   segment         : {g,f,e,d,c,b,a}, active-low
//   frame_tick      : one-cycle pulse after each input capture
import seg_pkg::*;

module seg_scan_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sign,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       lz_suppress,
  output logic [3:0] anode,
  output logic [6:0] segment,
  output logic       frame_tick
);

  localparam int              CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_e      state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shadow_t          sh_q;
  logic             capture;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick_q, tick_d;

  logic [3:0]       digitBcd;
  logic             digitBlank;
  logic [6:0]       decSeg;
  logic [6:0]       digitSeg;

  // Pick the shadowed digit for the current slot. Digit 1 is only a leading
  // zero when digit 2 is also zero; digit 3 carries no BCD value at all.
  always_comb begin
    digitBcd   = 4'd0;
    digitBlank = 1'b1;
    case (idx_q)
      2'd0: begin
        digitBcd   = sh_q.bcd0;
        digitBlank = 1'b0;
      end
      2'd1: begin
        digitBcd   = sh_q.bcd1;
        digitBlank = sh_q.lz && (sh_q.bcd2 == 4'd0) && (sh_q.bcd1 == 4'd0);
      end
      2'd2: begin
        digitBcd   = sh_q.bcd2;
        digitBlank = sh_q.lz && (sh_q.bcd2 == 4'd0);
      end
      default: begin
        digitBcd   = 4'd0;
        digitBlank = 1'b1;
      end
    endcase
  end

  seg_decode u_decode (
    .bcd_i   (digitBcd),
    .blank_i (digitBlank),
    .seg_o   (decSeg)
  );

  assign digitSeg = ((idx_q == 2'd3) && sh_q.sign) ? SEG_MINUS : decSeg;

  // Next-state logic. Outputs are computed for the state being entered so the
  // registered anode/segment change on the same edge as state and idx.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    anode_d = 4'b1111;
    seg_d   = SEG_BLANK;
    tick_d  = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
          capture = 1'b1;
          tick_d  = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            anode_d = ~(4'b0001 << idx_q);
            seg_d   = digitSeg;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              capture = 1'b1;
              tick_d  = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            anode_d = ~(4'b0001 << idx_q);
            seg_d   = digitSeg;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      sh_q    <= '0;
      anode_q <= 4'b1111;
      seg_q   <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
      if (capture) begin
        sh_q <= '{sign: sign, lz: lz_suppress, bcd2: bcd2, bcd1: bcd1, bcd0: bcd0};
      end
    end
  end

  assign anode      = anode_q;
  assign segment    = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl -- self-checking bench for seg_scan_ctrl (CLK_DIV=8,
// BLANK_CYC=2). A frame-position model pushes the expected outputs for every
// cycle onto a scoreboard queue; a table of display values carries the
// hand-derived segment pattern for each digit.
module tb_seg_scan_ctrl;

  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * CD;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PE = 7'b0000110;
  localparam logic [6:0] PM = 7'b0111111;
  localparam logic [6:0] PB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst, en, sign, lz;
  logic [3:0] bcd2, bcd1, bcd0;
  logic [3:0] anode;
  logic [6:0] segment;
  logic       frame_tick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sign        (sign),
    .bcd2        (bcd2),
    .bcd1        (bcd1),
    .bcd0        (bcd0),
    .lz_suppress (lz),
    .anode       (anode),
    .segment     (segment),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] sg;
    logic       tk;
  } exp_t;

  typedef struct {
    logic       sign;
    logic [3:0] b2, b1, b0;
    logic       lz;
    logic [6:0] e3, e2, e1, e0;
  } vec_t;

  exp_t       sbq[$];
  int         nVec = 0;
  int         nErr = 0;

  bit         mRun = 1'b0;
  int         mPos = 0;
  logic       mSign = 1'b0, mLz = 1'b0;
  logic [3:0] mB2 = 4'd0, mB1 = 4'd0, mB0 = 4'd0;

  bit         tblActive = 1'b0;
  logic [6:0] tblExp[4];

  function automatic logic [6:0] decodeRef(input logic [3:0] v);
    case (v)
      4'd0: return P0;
      4'd1: return P1;
      4'd2: return P2;
      4'd3: return P3;
      4'd4: return P4;
      4'd5: return P5;
      4'd6: return P6;
      4'd7: return P7;
      4'd8: return P8;
      4'd9: return P9;
      default: return PE;
    endcase
  endfunction

  function automatic logic [6:0] digitRef(input int d);
    case (d)
      0: return decodeRef(mB0);
      1: return (mLz && mB2 == 4'd0 && mB1 == 4'd0) ? PB : decodeRef(mB1);
      2: return (mLz && mB2 == 4'd0) ? PB : decodeRef(mB2);
      default: return mSign ? PM : PB;
    endcase
  endfunction

  // Reference behaviour at one rising edge: position within the frame decides
  // whether a digit is lit; the frame restarts from position 0 after any stop.
  task automatic modelEdge();
    exp_t e;
    e.tk = 1'b0;
    if (rst) begin
      mRun = 1'b0;
      mPos = 0;
      {mSign, mLz, mB2, mB1, mB0} = '0;
    end else if (!en) begin
      mRun = 1'b0;
      mPos = 0;
    end else begin
      if (!mRun) begin
        mRun = 1'b1;
        mPos = 0;
        e.tk = 1'b1;
      end else begin
        mPos = (mPos + 1) % FRAME;
        if (mPos == 0) e.tk = 1'b1;
      end
      if (e.tk) begin
        mSign = sign; mLz = lz; mB2 = bcd2; mB1 = bcd1; mB0 = bcd0;
      end
    end
    e.an = 4'b1111;
    e.sg = PB;
    if (mRun && (mPos % CD) >= BC) begin
      e.an[mPos / CD] = 1'b0;
      e.sg = digitRef(mPos / CD);
    end
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    int   d;
    if (sbq.size() == 0) begin
      nVec++;
      nErr++;
      $display("[TB] FAIL scoreboard: queue empty at t=%0t", $time);
      return;
    end
    e = sbq.pop_front();
    nVec++;
    if (anode !== e.an || segment !== e.sg || frame_tick !== e.tk) begin
      nErr++;
      $display("[TB] FAIL cycle t=%0t pos=%0d: got anode=%b seg=%b tick=%b, want anode=%b seg=%b tick=%b",
               $time, mPos, anode, segment, frame_tick, e.an, e.sg, e.tk);
    end
    if (tblActive && e.an != 4'b1111) begin
      d = mPos / CD;
      nVec++;
      if (segment !== tblExp[d]) begin
        nErr++;
        $display("[TB] FAIL table digit%0d t=%0t: got seg=%b, want seg=%b", d, $time, segment, tblExp[d]);
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] b2, input logic [3:0] b1,
                               input logic [3:0] b0, input logic l);
    sign = s; bcd2 = b2; bcd1 = b1; bcd0 = b0; lz = l;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic runUntilPos(input int target);
    int guard = 0;
    while (!(mRun && mPos == target) && guard < 4 * FRAME) begin
      stepCycle();
      guard++;
    end
    if (!(mRun && mPos == target)) begin
      nVec++;
      nErr++;
      $display("[TB] FAIL timeout: position %0d not reached, at %0d", target, mPos);
    end
  endtask

  task automatic setTable(input vec_t v);
    tblExp[3] = v.e3; tblExp[2] = v.e2; tblExp[1] = v.e1; tblExp[0] = v.e0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 4'd3, 4'd0,  4'd7, 1'b0, PM, P3, P0, P7};
    vecs[1] = '{1'b0, 4'd0, 4'd0,  4'd5, 1'b1, PB, PB, PB, P5};
    vecs[2] = '{1'b0, 4'd0, 4'd4,  4'd0, 1'b1, PB, PB, P4, P0};
    vecs[3] = '{1'b0, 4'd0, 4'd12, 4'd8, 1'b0, PB, P0, PE, P8};
    vecs[4] = '{1'b1, 4'd0, 4'd0,  4'd0, 1'b1, PM, PB, PB, P0};
    vecs[5] = '{1'b0, 4'd9, 4'd15, 4'd6, 1'b1, PB, P9, PE, P6};
    vecs[6] = '{1'b0, 4'd2, 4'd1,  4'd4, 1'b0, PB, P2, P1, P4};

    rst = 1'b1;
    en  = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

    // Reset held for three cycles, then idle with the scan disabled.
    repeat (3) stepCycle();
    rst = 1'b0;
    repeat (2) stepCycle();

    // Enable with the first table value: tick, two dark cycles, digit 0.
    applyStimulus(vecs[0].sign, vecs[0].b2, vecs[0].b1, vecs[0].b0, vecs[0].lz);
    en = 1'b1;
    setTable(vecs[0]);
    tblActive = 1'b1;
    repeat (FRAME) stepCycle();
    tblActive = 1'b0;

    // Table: each value is captured at a 3->0 wrap and checked for one frame.
    for (int i = 1; i < 7; i++) begin
      applyStimulus(vecs[i].sign, vecs[i].b2, vecs[i].b1, vecs[i].b0, vecs[i].lz);
      runUntilPos(FRAME - 1);
      setTable(vecs[i]);
      tblActive = 1'b1;
      repeat (FRAME) stepCycle();
      tblActive = 1'b0;
    end

    // Tearing: bcd0 changes during the digit-0 drive, old value must persist.
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd5, 1'b0);
    runUntilPos(FRAME - 1);
    tblExp[3] = PB; tblExp[2] = P0; tblExp[1] = P0; tblExp[0] = P5;
    tblActive = 1'b1;
    repeat (BC + 2) stepCycle();
    bcd0 = 4'd9;
    repeat (FRAME - BC - 2) stepCycle();
    tblExp[0] = P9;
    repeat (FRAME) stepCycle();
    tblActive = 1'b0;

    // Stop during a digit-2 drive, then restart from digit 0.
    runUntilPos(2 * CD + BC + 1);
    en = 1'b0;
    repeat (3) stepCycle();
    en = 1'b1;
    repeat (CD + 4) stepCycle();

    // Reset in the middle of a drive while the scan stays enabled.
    runUntilPos(CD + BC + 2);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    repeat (FRAME + 4) stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
